sprite_engine: RTL and testbench

- Parametrised per-scanline sprite pipeline that replaces the fixed 8-sprite oam/sprite-slice arrangement in the PPU renderer.
- Every scanline it does three things:
  - Evaluates all 64 primary OAM entries for the next line.
  - Fetches pattern bytes for up to NUM_SPRITES hits.
  - Serialises the hits into one prioritised sprite pixel stream for the final pixel mux.
- It adds a configurable sprites-per-line limit and true (non-buggy) overflow detection.

---
 rtl/ppu_pkg.sv | 22 ++
 rtl/sprite_slot.sv | 39 +++
 rtl/sprite_engine.sv | 133 +++++++++++++
 tb/tb_sprite_engine.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// ppu_pkg: shared sprite slot record, cycle landmarks, FSM states and helpers
package ppu_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, EVAL, WAIT, FETCH} state_t;
    typedef struct packed {
        logic [7:0] y;
        logic [7:0] tile;
        logic [7:0] attr;
        logic [7:0] x;
        logic [3:0] row;
        logic       is_sp0;
    } sprite_slot_t;
    localparam logic [8:0] EVAL_START  = 9'd65;
    localparam logic [8:0] FETCH_START = 9'd257;
    localparam logic [8:0] LOAD_CYCLE  = 9'd320;
    localparam int PPUCTRL_S = 3;
    localparam int PPUCTRL_H = 5;
    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7 - i];
        return r;
    endfunction
endpackage

// File: rtl/sprite_slot.sv
// sprite_slot: one render slot -- x delay counter, attribute latch and 2x8 pattern shifter
module sprite_slot (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] x_in,
    input  logic [7:0] attr_in,
    input  logic [7:0] p0_in,
    input  logic [7:0] p1_in,
    output logic [3:0] px,
    output logic       pri
);
    logic [7:0] x, attr, sh0, sh1;
    logic unused_ok;
    // count down to the sprite's left edge, then shift one pixel per visible dot
    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            attr <= '0;
            sh0 <= '0;
            sh1 <= '0;
        end else if (load) begin
            x <= x_in;
            attr <= attr_in;
            sh0 <= p0_in;
            sh1 <= p1_in;
        end else if (shift) begin
            if (x != 8'd0) x <= x - 8'd1;
            else begin
                sh0 <= {sh0[6:0], 1'b0};
                sh1 <= {sh1[6:0], 1'b0};
            end
        end
    end
    assign px = {attr[1:0], (x == 8'd0) ? {sh1[7], sh0[7]} : 2'b00};
    assign pri = attr[5];
    assign unused_ok = ^{attr[7:6], attr[4:2]};
endmodule

// File: rtl/sprite_engine.sv
// sprite_engine: per-scanline sprite evaluation, pattern fetch and prioritised pixel output (SPRITE_COUNT_EN adds sp_count)
module sprite_engine import ppu_pkg::*; #(
    parameter int NUM_SPRITES = 8,
    parameter int SLOT_CYCLES = 64 / NUM_SPRITES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rend,
    input  logic [8:0]  cycle,
    input  logic [8:0]  scan,
    input  logic        prerender,
    input  logic [7:0]  ppuctrl,
    input  logic        px_en,
    output logic [5:0]  oam_rd_idx,
    input  logic [31:0] oam_rd_data,
    output logic [12:0] pattern_idx,
    input  logic [7:0]  data_i,
    output logic [3:0]  sp_px,
    output logic        sp_pri,
    output logic        sp0_opaque,
    output logic        sp_of
`ifdef SPRITE_COUNT_EN
    ,
    output logic [$clog2(NUM_SPRITES+1)-1:0] sp_count
`endif
);
    localparam int CW = $clog2(NUM_SPRITES + 1);
    localparam int SW = $clog2(NUM_SPRITES);
    localparam int OW = $clog2(SLOT_CYCLES);
    state_t state;
    logic [CW-1:0] count;
    sprite_slot_t oam2 [NUM_SPRITES];
    logic [7:0] pat0 [NUM_SPRITES], pat1 [NUM_SPRITES], p0n [NUM_SPRITES], p1n [NUM_SPRITES];
    logic [3:0] slot_px [NUM_SPRITES];
    logic slot_pri [NUM_SPRITES];
    logic sp0_flag, cmp, hit, fetch, cap_en, plane, load, unused_ok;
    logic [8:0] d;
    logic [5:0] t;
    logic [SW-1:0] s;
    logic [OW-1:0] o;
    logic [3:0] r;
    logic [7:0] capv, tile, attr;
    assign d = scan - {1'b0, oam_rd_data[7:0]};
    assign hit = d < (ppuctrl[PPUCTRL_H] ? 9'd16 : 9'd8);
    assign cmp = rend && state == EVAL && cycle > EVAL_START && cycle <= EVAL_START + 9'd64;
    assign oam_rd_idx = (rend && state == EVAL && cycle >= EVAL_START && cycle < EVAL_START + 9'd64) ? 6'(cycle - EVAL_START) : '0;
    assign fetch = rend && state == FETCH;
    assign t = 6'(cycle - FETCH_START);
    assign s = t[5:OW];
    assign o = t[OW-1:0];
    assign plane = o[1];
    assign tile = oam2[s].tile;
    assign attr = oam2[s].attr;
    assign r = attr[7] ? ~oam2[s].row : oam2[s].row;
    assign pattern_idx = !fetch ? '0 : ppuctrl[PPUCTRL_H] ? {tile[0], tile[7:1], r[3], plane, r[2:0]} : {ppuctrl[PPUCTRL_S], tile, plane, r[2:0]};
    assign cap_en = fetch && o[0] && (o >> 2) == '0;
    assign capv = ({1'b0, s} >= count) ? 8'd0 : attr[6] ? rev8(data_i) : data_i;
    assign load = fetch && cycle == LOAD_CYCLE;
    // next pattern latch values, so a capture on the load cycle reaches the shifter directly
    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            p0n[i] = (cap_en && !plane && s == SW'(i)) ? capv : pat0[i];
            p1n[i] = (cap_en && plane && s == SW'(i)) ? capv : pat1[i];
        end
    end
    // pattern byte latches filled during the fetch window
    always_ff @(posedge clk) begin
        if (rst) begin
            pat0 <= '{default: '0};
            pat1 <= '{default: '0};
        end else begin
            pat0 <= p0n;
            pat1 <= p1n;
        end
    end
    // line sequencer, secondary OAM fill and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            sp_of <= 1'b0;
            sp0_flag <= 1'b0;
            oam2 <= '{default: '0};
        end else begin
            if (!rend) state <= IDLE;
            else case (state)
                IDLE:  if (cycle == 9'd1) state <= CLEAR;
                CLEAR: if (cycle == EVAL_START - 9'd1) state <= EVAL;
                EVAL:  if (cycle == EVAL_START + 9'd64) state <= WAIT;
                WAIT:  if (cycle == FETCH_START - 9'd1) state <= FETCH;
                FETCH: if (cycle == LOAD_CYCLE) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (rend && (state == CLEAR || (state == IDLE && cycle == 9'd1))) count <= '0;
            if (cmp && hit && count < CW'(NUM_SPRITES)) begin
                oam2[count[SW-1:0]] <= '{y: oam_rd_data[7:0], tile: oam_rd_data[15:8], attr: oam_rd_data[23:16],
                                         x: oam_rd_data[31:24], row: d[3:0], is_sp0: cycle == EVAL_START + 9'd1};
                count <= count + 1'b1;
            end
            if (prerender && cycle == 9'd1) sp_of <= 1'b0;
            else if (cmp && hit && count == CW'(NUM_SPRITES)) sp_of <= 1'b1;
            if (load) sp0_flag <= oam2[0].is_sp0;
        end
    end
`ifdef SPRITE_COUNT_EN
    // sprites stored for the line being rendered
    always_ff @(posedge clk) begin
        if (rst) sp_count <= '0;
        else if (load) sp_count <= count;
    end
`endif
    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_slot
        sprite_slot u_slot (
            .clk(clk), .rst(rst), .load(load), .shift(rend && px_en),
            .x_in(oam2[g].x), .attr_in(oam2[g].attr), .p0_in(p0n[g]), .p1_in(p1n[g]),
            .px(slot_px[g]), .pri(slot_pri[g])
        );
    end
    // lowest-index opaque slot wins; y fields are only needed for the hit test
    always_comb begin
        sp_px = '0;
        sp_pri = 1'b1;
        unused_ok = ^{ppuctrl[7:6], ppuctrl[4], ppuctrl[2:0]};
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            unused_ok = unused_ok ^ (^oam2[i].y);
            if (slot_px[i][1:0] != 2'b00) begin
                sp_px = slot_px[i];
                sp_pri = slot_pri[i];
            end
        end
        sp0_opaque = sp0_flag && slot_px[0][1:0] != 2'b00;
    end
endmodule

// File: tb/tb_sprite_engine.sv
// tb_sprite_engine: directed scanline scenarios on 8- and 16-slot engines
module tb_sprite_engine;
    logic clk = 1'b0, rst, rend, prerender, px_en;
    logic [8:0] cycle, scan;
    logic [7:0] ppuctrl;
    logic [5:0] idx_8, idx_16;
    logic [31:0] oq_8, oq_16;
    logic [12:0] pa_8, pa_16;
    logic [7:0] cq_8, cq_16;
    logic [3:0] spx_8, spx_16;
    logic pri_8, pri_16, s0_8, s0_16, of_8, of_16;
    logic [31:0] oam [64];
    logic [7:0] chr [8192];
    logic [3:0] px8 [256], px16 [256];
    logic pri8 [256], s0o8 [256];
    logic of8 [341], of16 [341];
    logic [12:0] pa8 [341];
    logic [5:0] idx8 [341];
    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        oq_8 <= oam[idx_8];
        oq_16 <= oam[idx_16];
        cq_8 <= chr[pa_8];
        cq_16 <= chr[pa_16];
    end

    sprite_engine u_dut8 (
        .clk(clk), .rst(rst), .rend(rend), .cycle(cycle), .scan(scan), .prerender(prerender),
        .ppuctrl(ppuctrl), .px_en(px_en), .oam_rd_idx(idx_8), .oam_rd_data(oq_8),
        .pattern_idx(pa_8), .data_i(cq_8), .sp_px(spx_8), .sp_pri(pri_8),
        .sp0_opaque(s0_8), .sp_of(of_8)
    );
    sprite_engine #(.NUM_SPRITES(16)) u_dut16 (
        .clk(clk), .rst(rst), .rend(rend), .cycle(cycle), .scan(scan), .prerender(prerender),
        .ppuctrl(ppuctrl), .px_en(px_en), .oam_rd_idx(idx_16), .oam_rd_data(oq_16),
        .pattern_idx(pa_16), .data_i(cq_16), .sp_px(spx_16), .sp_pri(pri_16),
        .sp0_opaque(s0_16), .sp_of(of_16)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic oam_clear();
        for (int i = 0; i < 64; i++) oam[i] = {8'd0, 8'd0, 8'd0, 8'hF0};
    endtask

    task automatic run_line(input logic [8:0] s, input logic pre, input int rst_at);
        scan = s;
        prerender = pre;
        for (int c = 0; c <= 340; c++) begin
            cycle = 9'(c);
            px_en = c >= 1 && c <= 256;
            rst = c == rst_at;
            #2;
            if (c >= 1 && c <= 256) begin
                px8[c-1] = spx_8;
                px16[c-1] = spx_16;
                pri8[c-1] = pri_8;
                s0o8[c-1] = s0_8;
            end
            of8[c] = of_8;
            of16[c] = of_16;
            pa8[c] = pa_8;
            idx8[c] = idx_8;
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic setup_a();
        oam_clear();
        for (int i = 0; i < 10; i++) oam[i] = {8'(i), 8'h00, 8'(i), 8'd10};
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) chr[i] = 8'h00;
        for (int n = 0; n < 10; n++) chr[(n << 4) | 1] = 8'h80;
        chr[13'h030] = 8'h01;
        chr[13'h040] = 8'h80;
        chr[13'h058] = 8'hC0;
        oam_clear();
        rst = 1'b1; rend = 1'b1; prerender = 1'b0; px_en = 1'b0;
        cycle = '0; scan = '0; ppuctrl = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_px", 16'(spx_8), 16'h0);
        chk("rst_pri", 16'(pri_8), 16'h1);
        chk("rst_s0", 16'(s0_8), 16'h0);
        chk("rst_of", 16'(of_8), 16'h0);
        chk("rst_idx", 16'(idx_8), 16'h0);
        chk("rst_pa", 16'(pa_8), 16'h0);
        rst = 1'b0;
        setup_a();
        run_line(9'd11, 1'b0, -1);
        chk("idx_c70", 16'(idx8[70]), 16'd5);
        chk("idx_c129", 16'(idx8[129]), 16'd0);
        chk("of8_ten_hits", 16'(of8[340]), 16'h1);
        chk("of16_ten_hits", 16'(of16[340]), 16'h0);
        oam_clear();
        oam[0] = {8'd0, 8'h80, 8'h21, 8'd47};
        ppuctrl = 8'h20;
        run_line(9'd50, 1'b0, -1);
        chk("a8_px0", 16'(px8[0]), 16'h1);
        chk("a8_sp0_px0", 16'(s0o8[0]), 16'h1);
        chk("a8_sp0_px1", 16'(s0o8[1]), 16'h0);
        chk("a8_px7", 16'(px8[7]), 16'h1);
        chk("a8_px8_dropped", 16'(px8[8]), 16'h0);
        chk("a8_px9_dropped", 16'(px8[9]), 16'h0);
        chk("a16_px8", 16'(px16[8]), 16'h1);
        chk("a16_px9", 16'(px16[9]), 16'h1);
        chk("a16_px12_empty", 16'(px16[12]), 16'h0);
        chk("a8_pri_empty", 16'(pri8[20]), 16'h1);
        chk("b_pa_plane0", 16'(pa8[257]), 16'h1214);
        chk("b_pa_plane1", 16'(pa8[259]), 16'h121C);
        chk("of8_sticky", 16'(of8[340]), 16'h1);
        oam_clear();
        oam[0] = {8'd5, 8'h40, 8'd3, 8'd60};
        ppuctrl = 8'h00;
        run_line(9'd60, 1'b0, -1);
        oam_clear();
        oam[0] = {8'd30, 8'h20, 8'd4, 8'd70};
        oam[1] = {8'd30, 8'h03, 8'd5, 8'd70};
        run_line(9'd70, 1'b0, -1);
        chk("c_px4", 16'(px8[4]), 16'h0);
        chk("c_px5_flip", 16'(px8[5]), 16'h1);
        chk("c_px6", 16'(px8[6]), 16'h0);
        run_line(9'd0, 1'b1, -1);
        chk("d_px30", 16'(px8[30]), 16'h1);
        chk("d_pri30", 16'(pri8[30]), 16'h1);
        chk("d_sp0_30", 16'(s0o8[30]), 16'h1);
        chk("d_px31", 16'(px8[31]), 16'hE);
        chk("d_pri31", 16'(pri8[31]), 16'h0);
        chk("d_sp0_31", 16'(s0o8[31]), 16'h0);
        chk("pre_of_c1", 16'(of8[1]), 16'h1);
        chk("pre_of_c2", 16'(of8[2]), 16'h0);
        setup_a();
        run_line(9'd11, 1'b0, 200);
        chk("l6_of_set", 16'(of8[150]), 16'h1);
        chk("l6_of_rst", 16'(of8[201]), 16'h0);
        chk("l6_pri_rst", 16'(pri8[205]), 16'h1);
        chk("l6_pa_idle", 16'(pa8[257]), 16'h0);
        chk("l6_of_end", 16'(of8[340]), 16'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
